dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter MEM_BYTES, default 8192, the data memory size in bytes.
REQ-002 The block SHALL have parameter ACC_CYCLES, default 1 (range 1..15), the cycles each access holds the memory.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 The block SHALL have port clk, input, 1, the rising-edge clock.
REQ-005 The block SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-006 The block SHALL have ports reqA/reqB, input, 1, access request from core port A and DMA port B.
REQ-007 The block SHALL have ports weA/weB, input, 1, store (1) or load (0).
REQ-008 The block SHALL have ports sbA/sbB, input, 1, byte store (1) or word store (0).
REQ-009 The block SHALL have ports addrA/addrB and wdataA/wdataB, input, 32 each, byte address and store data.
REQ-010 The block SHALL have ports gntA/gntB, output, 1, a one-cycle pulse when the request is accepted.
REQ-011 The block SHALL have ports doneA/doneB, output, 1, a one-cycle completion pulse.
REQ-012 The block SHALL have ports errA/errB, output, 1, valid with done, marking an access that was rejected.
REQ-013 The block SHALL have ports rdataA/rdataB, output, 32, load data, valid with done.
REQ-014 The block SHALL have memory-side ports dataAddress (32), writeData (32), memWrite (1) and sb (1) as outputs, and data (32) as a combinational read input.

Function
REQ-015 The FSM SHALL have states IDLE, ACCESS and RESP.
REQ-016 IDLE SHALL move to ACCESS when either request is high, pulsing the winner's gnt and latching its we, sb, addr and wdata in that cycle.
REQ-017 Requesters SHALL hold req and all fields stable until gnt; a request dropped before gnt is ignored.
REQ-018 ACCESS SHALL last exactly ACC_CYCLES cycles, counted by a 4-bit down-counter, driving the memory from the latched fields the whole time.
REQ-019 memWrite SHALL be high only in the last ACCESS cycle of a store, so exactly one write occurs per store.
REQ-020 In the last ACCESS cycle, data SHALL be registered into the winner's rdata for loads; for stores, rdata SHALL keep its previous value.
REQ-021 RESP SHALL pulse the winner's done for one cycle and return to IDLE.
REQ-022 Latency SHALL be fixed: gnt at cycle t, done at t+ACC_CYCLES+1, next gnt no earlier than t+ACC_CYCLES+2.
REQ-023 Memory bytes SHALL be little-endian: a word at addr occupies addr..addr+3 with the LSB at addr, and a byte store touches addr only.
REQ-024 A word access with addr[1:0]!=0, or any access with addr+size > MEM_BYTES, SHALL be rejected: gnt still pulses, memWrite stays 0, rdata becomes 0, and err is asserted with done.
REQ-025 A request arriving while the FSM is in ACCESS or RESP SHALL wait; the loser of a simultaneous request SHALL wait with no gnt.
REQ-026 All outputs SHALL be registered except the memory-side ports, which are driven from latched registers.

Reset
REQ-027 Asserting rst_n low SHALL immediately force state IDLE, counter 0, all gnt/done/err 0, rdataA/rdataB 0, memWrite 0, dataAddress/writeData 0, sb 0, and lastGrant=B.
REQ-028 A reset during ACCESS SHALL abort the access with no memory write and no done.

Configuration
REQ-029 When DMEM_ARB_RR_EN is defined, arbitration SHALL be round-robin: on simultaneous requests, the port not named in lastGrant wins, and lastGrant updates on every gnt.
REQ-030 When DMEM_ARB_RR_EN is undefined, port A SHALL always win, and lastGrant SHALL be absent.

Structure
REQ-031 A shared package SHALL hold the state enum (IDLE/ACCESS/RESP), the port-select typedef (PORT_A/PORT_B) and the alignment and bounds-check constants.
REQ-032 Arbitration SHALL be one sub-module, dmem_arb_pick, taking (reqA, reqB, lastGrant) and returning the winner, with the round-robin/fixed choice made inside it.

Verification
REQ-033 A bench SHALL check: ACC_CYCLES=1, A stores word 0x0D0C0B0A to addr 20 -> gntA at t, one memWrite at t+1, doneA at t+2; then A loads 20 -> rdataA=0x0D0C0B0A.
REQ-034 A bench SHALL check: B byte-stores 0xFF to addr 21, then loads word 20 -> rdataB=0x0D0CFF0A, errB=0.
REQ-035 A bench SHALL check: with DMEM_ARB_RR_EN, reqA and reqB held together for four accesses -> grant order A,B,A,B; without the macro -> A,A,A,A.
REQ-036 A bench SHALL check: word load at addr 22 and word store at addr 8190 -> err with done, rdata=0, memWrite never asserted.
REQ-037 A bench SHALL check: ACC_CYCLES=3, rst_n pulled low in the second ACCESS cycle of a store -> memory unchanged, no done, all outputs at reset values.
REQ-038 A bench SHALL check: reqB raised in the RESP cycle of an A access -> gntB exactly one cycle later, with IDLE re-entered first.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and access-check constants for the two-port data-memory arbiter.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_t;

    localparam logic [1:0]  WORD_ALIGN_MASK = 2'b11;
    localparam logic [32:0] WORD_SIZE       = 33'd4;
    localparam logic [32:0] BYTE_SIZE       = 33'd1;

    // 33-bit end address so an access near 4 GiB cannot wrap past the bound
    function automatic logic access_ok(
        input logic [31:0] addr,
        input logic        byte_acc,
        input logic [32:0] mem_bytes
    );
        logic [32:0] w_end;
        logic        w_misaligned;
        w_end        = {1'b0, addr} + (byte_acc ? BYTE_SIZE : WORD_SIZE);
        w_misaligned = !byte_acc && ((addr[1:0] & WORD_ALIGN_MASK) != 2'b00);
        return !w_misaligned && (w_end <= mem_bytes);
    endfunction

endpackage

// File: rtl/dmem_arbiter_pick.sv
// Winner selection for the data-memory arbiter; round-robin when DMEM_ARB_RR_EN
// is defined, otherwise port A always wins a tie.
module dmem_arb_pick
    import dmem_arbiter_pkg::*;
(
    input  logic  reqA,
    input  logic  reqB,
`ifdef DMEM_ARB_RR_EN
    input  port_t lastGrant,
`endif
    output port_t winner
);

    always_comb begin
        winner = PORT_A;
        if (reqA && reqB) begin
`ifdef DMEM_ARB_RR_EN
            winner = (lastGrant == PORT_A) ? PORT_B : PORT_A;
`else
            winner = PORT_A;
`endif
        end else if (reqB) begin
            winner = PORT_B;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port (core A, DMA B) data-memory arbiter with fixed-latency accesses.
// Define DMEM_ARB_RR_EN for round-robin arbitration; default is fixed A priority.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int MEM_BYTES  = 8192,
    parameter int ACC_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        reqA,
    input  logic        reqB,
    input  logic        weA,
    input  logic        weB,
    input  logic        sbA,
    input  logic        sbB,
    input  logic [31:0] addrA,
    input  logic [31:0] addrB,
    input  logic [31:0] wdataA,
    input  logic [31:0] wdataB,
    output logic        gntA,
    output logic        gntB,
    output logic        doneA,
    output logic        doneB,
    output logic        errA,
    output logic        errB,
    output logic [31:0] rdataA,
    output logic [31:0] rdataB,
    output logic [31:0] dataAddress,
    output logic [31:0] writeData,
    output logic        memWrite,
    output logic        sb,
    input  logic [31:0] data
);

    state_t      r_state;
    logic [3:0]  r_cnt;
    port_t       r_sel;
    logic        r_we;
    logic        r_sb;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_rej;
    logic        r_gntA, r_gntB;
    logic        r_doneA, r_doneB;
    logic        r_errA, r_errB;
    logic [31:0] r_rdataA, r_rdataB;
    logic        r_memWrite;
`ifdef DMEM_ARB_RR_EN
    port_t       r_lastGrant;
`endif

    port_t       w_win;
    logic        w_we;
    logic        w_sb;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic        w_ok;

    dmem_arb_pick u_pick (
        .reqA      (reqA),
        .reqB      (reqB),
`ifdef DMEM_ARB_RR_EN
        .lastGrant (r_lastGrant),
`endif
        .winner    (w_win)
    );

    always_comb begin
        w_we    = weA;
        w_sb    = sbA;
        w_addr  = addrA;
        w_wdata = wdataA;
        if (w_win == PORT_B) begin
            w_we    = weB;
            w_sb    = sbB;
            w_addr  = addrB;
            w_wdata = wdataB;
        end
        w_ok = access_ok(w_addr, w_sb, 33'(MEM_BYTES));
    end

    // Outputs are registered, so each pulse appears one cycle after the state
    // that produces it: gnt after IDLE, memWrite after the last ACCESS, done after RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_sel      <= PORT_A;
            r_we       <= 1'b0;
            r_sb       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rej      <= 1'b0;
            r_gntA     <= 1'b0;
            r_gntB     <= 1'b0;
            r_doneA    <= 1'b0;
            r_doneB    <= 1'b0;
            r_errA     <= 1'b0;
            r_errB     <= 1'b0;
            r_rdataA   <= '0;
            r_rdataB   <= '0;
            r_memWrite <= 1'b0;
`ifdef DMEM_ARB_RR_EN
            r_lastGrant <= PORT_B;
`endif
        end else begin
            r_gntA     <= 1'b0;
            r_gntB     <= 1'b0;
            r_doneA    <= 1'b0;
            r_doneB    <= 1'b0;
            r_errA     <= 1'b0;
            r_errB     <= 1'b0;
            r_memWrite <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (reqA || reqB) begin
                        r_state <= ACCESS;
                        r_cnt   <= 4'(ACC_CYCLES);
                        r_sel   <= w_win;
                        r_we    <= w_we;
                        r_sb    <= w_sb;
                        r_addr  <= w_addr;
                        r_wdata <= w_wdata;
                        r_rej   <= !w_ok;
                        if (w_win == PORT_A) r_gntA <= 1'b1;
                        else                 r_gntB <= 1'b1;
`ifdef DMEM_ARB_RR_EN
                        r_lastGrant <= w_win;
`endif
                    end
                end
                ACCESS: begin
                    if (r_cnt <= 4'd1) begin
                        r_state <= RESP;
                        r_cnt   <= '0;
                        if (r_rej) begin
                            if (r_sel == PORT_A) r_rdataA <= '0;
                            else                 r_rdataB <= '0;
                        end else if (r_we) begin
                            r_memWrite <= 1'b1;
                        end else begin
                            if (r_sel == PORT_A) r_rdataA <= data;
                            else                 r_rdataB <= data;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                    if (r_sel == PORT_A) begin
                        r_doneA <= 1'b1;
                        r_errA  <= r_rej;
                    end else begin
                        r_doneB <= 1'b1;
                        r_errB  <= r_rej;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign gntA        = r_gntA;
    assign gntB        = r_gntB;
    assign doneA       = r_doneA;
    assign doneB       = r_doneB;
    assign errA        = r_errA;
    assign errB        = r_errB;
    assign rdataA      = r_rdataA;
    assign rdataB      = r_rdataB;
    assign dataAddress = r_addr;
    assign writeData   = r_wdata;
    assign memWrite    = r_memWrite;
    assign sb          = r_sb;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: one instance at ACC_CYCLES=1, one at ACC_CYCLES=3,
// each backed by a little-endian byte-array memory model.
`timescale 1ns/1ps
module tb_dmem_arbiter;

    localparam int MEMB = 8192;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // ---- instance with ACC_CYCLES = 1 ----
    logic        rst_n;
    logic        reqA, reqB, weA, weB, sbA, sbB;
    logic [31:0] addrA, addrB, wdataA, wdataB;
    logic        gntA, gntB, doneA, doneB, errA, errB;
    logic [31:0] rdataA, rdataB, dataAddress, writeData, data;
    logic        memWrite, sb;

    dmem_arbiter #(.MEM_BYTES(MEMB), .ACC_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .reqA(reqA), .reqB(reqB), .weA(weA), .weB(weB), .sbA(sbA), .sbB(sbB),
        .addrA(addrA), .addrB(addrB), .wdataA(wdataA), .wdataB(wdataB),
        .gntA(gntA), .gntB(gntB), .doneA(doneA), .doneB(doneB), .errA(errA), .errB(errB),
        .rdataA(rdataA), .rdataB(rdataB),
        .dataAddress(dataAddress), .writeData(writeData), .memWrite(memWrite), .sb(sb),
        .data(data)
    );

    // ---- instance with ACC_CYCLES = 3 (port B idle) ----
    logic        rst3_n;
    logic        reqA3, weA3, sbA3;
    logic [31:0] addrA3, wdataA3;
    logic        gntA3, gntB3, doneA3, doneB3, errA3, errB3;
    logic [31:0] rdataA3, rdataB3, dataAddress3, writeData3, data3;
    logic        memWrite3, sb3;

    dmem_arbiter #(.MEM_BYTES(MEMB), .ACC_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst3_n),
        .reqA(reqA3), .reqB(1'b0), .weA(weA3), .weB(1'b0), .sbA(sbA3), .sbB(1'b0),
        .addrA(addrA3), .addrB(32'd0), .wdataA(wdataA3), .wdataB(32'd0),
        .gntA(gntA3), .gntB(gntB3), .doneA(doneA3), .doneB(doneB3), .errA(errA3), .errB(errB3),
        .rdataA(rdataA3), .rdataB(rdataB3),
        .dataAddress(dataAddress3), .writeData(writeData3), .memWrite(memWrite3), .sb(sb3),
        .data(data3)
    );

    // ---- memory models ----
    bit [7:0] mem1 [MEMB];
    bit [7:0] mem3 [MEMB];
    int       wr1 = 0;
    int       wr3 = 0;

    always_comb begin
        data = '0;
        if (dataAddress <= 32'(MEMB - 4))
            data = {mem1[dataAddress + 3], mem1[dataAddress + 2], mem1[dataAddress + 1], mem1[dataAddress]};
    end

    always_comb begin
        data3 = '0;
        if (dataAddress3 <= 32'(MEMB - 4))
            data3 = {mem3[dataAddress3 + 3], mem3[dataAddress3 + 2], mem3[dataAddress3 + 1], mem3[dataAddress3]};
    end

    always @(posedge clk) begin
        if (memWrite) begin
            wr1 <= wr1 + 1;
            if (sb) begin
                if (dataAddress < 32'(MEMB)) mem1[dataAddress] <= writeData[7:0];
            end else if (dataAddress <= 32'(MEMB - 4)) begin
                mem1[dataAddress]     <= writeData[7:0];
                mem1[dataAddress + 1] <= writeData[15:8];
                mem1[dataAddress + 2] <= writeData[23:16];
                mem1[dataAddress + 3] <= writeData[31:24];
            end
        end
    end

    always @(posedge clk) begin
        if (memWrite3) begin
            wr3 <= wr3 + 1;
            if (sb3) begin
                if (dataAddress3 < 32'(MEMB)) mem3[dataAddress3] <= writeData3[7:0];
            end else if (dataAddress3 <= 32'(MEMB - 4)) begin
                mem3[dataAddress3]     <= writeData3[7:0];
                mem3[dataAddress3 + 1] <= writeData3[15:8];
                mem3[dataAddress3 + 2] <= writeData3[23:16];
                mem3[dataAddress3 + 3] <= writeData3[31:24];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one ACC_CYCLES=1 transaction on dut1 and reports what was observed.
    task automatic run1(input logic pb, input logic we, input logic s,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic g_ok, output logic d_ok, output logic e,
                        output logic [31:0] rd, output int nw);
        int w0;
        if (!pb) begin
            reqA = 1'b1; weA = we; sbA = s; addrA = a; wdataA = wd;
        end else begin
            reqB = 1'b1; weB = we; sbB = s; addrB = a; wdataB = wd;
        end
        w0 = wr1;
        step();
        g_ok = pb ? (gntB && !gntA) : (gntA && !gntB);
        reqA = 1'b0;
        reqB = 1'b0;
        step();
        step();
        d_ok = pb ? (doneB && !doneA) : (doneA && !doneB);
        e    = pb ? errB : errA;
        rd   = pb ? rdataB : rdataA;
        nw   = wr1 - w0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rst3_n = 1'b0;
        reqA = 0; reqB = 0; weA = 0; weB = 0; sbA = 0; sbB = 0;
        addrA = '0; addrB = '0; wdataA = '0; wdataB = '0;
        reqA3 = 0; weA3 = 0; sbA3 = 0; addrA3 = '0; wdataA3 = '0;
        step(); step();
        n_cmp++;
        if ({gntA, gntB, doneA, doneB, errA, errB, memWrite, sb} !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_flags: got %b want 00000000",
                     {gntA, gntB, doneA, doneB, errA, errB, memWrite, sb});
        end
        n_cmp++;
        if ({rdataA, rdataB, dataAddress, writeData} !== 128'd0) begin
            n_bad++;
            $display("FAIL reset_buses: got %h %h %h %h want all 0", rdataA, rdataB, dataAddress, writeData);
        end
        rst_n = 1'b1; rst3_n = 1'b1;
        step();
    endtask

    task automatic test_store_load();
        int          w0;
        logic        g, d, e;
        logic [31:0] rd;
        int          nw;
        reqA = 1'b1; weA = 1'b1; sbA = 1'b0; addrA = 32'd20; wdataA = 32'h0D0C0B0A;
        w0 = wr1;
        step();
        n_cmp++;
        if ({gntA, gntB, memWrite} !== 3'b100) begin
            n_bad++; $display("FAIL st_gnt_t: got gntA,gntB,memWrite=%b want 100", {gntA, gntB, memWrite});
        end
        reqA = 1'b0;
        step();
        n_cmp++;
        if ({memWrite, doneA, sb, dataAddress, writeData} !== {1'b1, 1'b0, 1'b0, 32'd20, 32'h0D0C0B0A}) begin
            n_bad++;
            $display("FAIL st_write_t1: got memWrite=%b done=%b sb=%b addr=%0d wd=%h want 1 0 0 20 0d0c0b0a",
                     memWrite, doneA, sb, dataAddress, writeData);
        end
        step();
        n_cmp++;
        if ({doneA, errA, memWrite} !== 3'b100 || (wr1 - w0) !== 1) begin
            n_bad++;
            $display("FAIL st_done_t2: got done,err,memWrite=%b writes=%0d want 100 1",
                     {doneA, errA, memWrite}, wr1 - w0);
        end
        run1(1'b0, 1'b0, 1'b0, 32'd20, 32'd0, g, d, e, rd, nw);
        n_cmp++;
        if ({g, d, e} !== 3'b110 || rd !== 32'h0D0C0B0A || nw !== 0) begin
            n_bad++;
            $display("FAIL ld_word20: got g,d,e=%b rdataA=%h writes=%0d want 110 0d0c0b0a 0", {g, d, e}, rd, nw);
        end
    endtask

    task automatic test_byte_store();
        logic        g, d, e;
        logic [31:0] rd;
        int          nw;
        run1(1'b1, 1'b1, 1'b1, 32'd21, 32'h000000FF, g, d, e, rd, nw);
        n_cmp++;
        if ({g, d, e} !== 3'b110 || nw !== 1) begin
            n_bad++; $display("FAIL sb_store21: got g,d,e=%b writes=%0d want 110 1", {g, d, e}, nw);
        end
        run1(1'b1, 1'b0, 1'b0, 32'd20, 32'd0, g, d, e, rd, nw);
        n_cmp++;
        if ({g, d, e} !== 3'b110 || rd !== 32'h0D0CFF0A) begin
            n_bad++; $display("FAIL sb_load20: got g,d,e=%b rdataB=%h want 110 0d0cff0a", {g, d, e}, rd);
        end
    endtask

    task automatic test_arbitration();
        int         ng;
        logic [3:0] order;
        logic [3:0] exp_order;
        logic       both;
        ng = 0; order = '0; both = 1'b0;
`ifdef DMEM_ARB_RR_EN
        exp_order = 4'b1010;
`else
        exp_order = 4'b0000;
`endif
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        reqA = 1'b1; weA = 1'b0; sbA = 1'b0; addrA = 32'd20;
        reqB = 1'b1; weB = 1'b0; sbB = 1'b0; addrB = 32'd24;
        for (int i = 0; i < 20 && ng < 4; i++) begin
            step();
            if (gntA && gntB) both = 1'b1;
            else if (gntA) begin order[ng] = 1'b0; ng++; end
            else if (gntB) begin order[ng] = 1'b1; ng++; end
            if (ng == 4) begin reqA = 1'b0; reqB = 1'b0; end
        end
        reqA = 1'b0; reqB = 1'b0;
        step(); step();
        n_cmp++;
        if (ng !== 4 || both !== 1'b0) begin
            n_bad++; $display("FAIL arb_count: got grants=%0d both=%b want 4 0", ng, both);
        end
        n_cmp++;
        if (order !== exp_order) begin
            n_bad++; $display("FAIL arb_order: got %b want %b (bit i = 1 means B)", order, exp_order);
        end
    endtask

    task automatic test_reject();
        logic        g, d, e;
        logic [31:0] rd;
        int          nw;
        run1(1'b0, 1'b0, 1'b0, 32'd22, 32'd0, g, d, e, rd, nw);
        n_cmp++;
        if ({g, d, e} !== 3'b111 || rd !== 32'd0 || nw !== 0) begin
            n_bad++; $display("FAIL rej_load22: got g,d,e=%b rdataA=%h writes=%0d want 111 0 0", {g, d, e}, rd, nw);
        end
        run1(1'b1, 1'b1, 1'b0, 32'd8190, 32'hDEADBEEF, g, d, e, rd, nw);
        n_cmp++;
        if ({g, d, e} !== 3'b111 || nw !== 0) begin
            n_bad++; $display("FAIL rej_store8190: got g,d,e=%b writes=%0d want 111 0", {g, d, e}, nw);
        end
        run1(1'b0, 1'b1, 1'b0, 32'd8188, 32'hA1B2C3D4, g, d, e, rd, nw);
        n_cmp++;
        if ({g, d, e} !== 3'b110 || nw !== 1) begin
            n_bad++; $display("FAIL edge_store8188: got g,d,e=%b writes=%0d want 110 1", {g, d, e}, nw);
        end
        run1(1'b1, 1'b0, 1'b0, 32'd8188, 32'd0, g, d, e, rd, nw);
        n_cmp++;
        if ({g, d, e} !== 3'b110 || rd !== 32'hA1B2C3D4) begin
            n_bad++; $display("FAIL edge_load8188: got g,d,e=%b rdataB=%h want 110 a1b2c3d4", {g, d, e}, rd);
        end
        run1(1'b1, 1'b1, 1'b1, 32'd8192, 32'h00000077, g, d, e, rd, nw);
        n_cmp++;
        if ({g, d, e} !== 3'b111 || rd !== 32'd0 || nw !== 0) begin
            n_bad++; $display("FAIL rej_byte8192: got g,d,e=%b rdataB=%h writes=%0d want 111 0 0", {g, d, e}, rd, nw);
        end
        run1(1'b0, 1'b1, 1'b1, 32'd8191, 32'h00000077, g, d, e, rd, nw);
        n_cmp++;
        if ({g, d, e} !== 3'b110 || nw !== 1 || mem1[8191] !== 8'h77) begin
            n_bad++;
            $display("FAIL edge_byte8191: got g,d,e=%b writes=%0d byte=%h want 110 1 77", {g, d, e}, nw, mem1[8191]);
        end
    endtask

    task automatic test_wait();
        logic early;
        reqA = 1'b1; weA = 1'b0; sbA = 1'b0; addrA = 32'd20;
        step();
        reqA = 1'b0;
        reqB = 1'b1; weB = 1'b0; sbB = 1'b0; addrB = 32'd24;
        early = gntB;
        step();
        early = early | gntB;
        step();
        early = early | gntB;
        n_cmp++;
        if (early !== 1'b0 || doneA !== 1'b1) begin
            n_bad++; $display("FAIL wait_busy: got early_gntB=%b doneA=%b want 0 1", early, doneA);
        end
        step();
        n_cmp++;
        if (gntB !== 1'b1) begin
            n_bad++; $display("FAIL wait_gntB: got %b want 1", gntB);
        end
        reqB = 1'b0;
        step(); step();
    endtask

    task automatic test_resp_handoff();
        reqA = 1'b1; weA = 1'b0; sbA = 1'b0; addrA = 32'd20;
        step();
        reqA = 1'b0;
        step(); step();
        n_cmp++;
        if (doneA !== 1'b1) begin
            n_bad++; $display("FAIL hand_doneA: got %b want 1", doneA);
        end
        reqB = 1'b1; weB = 1'b0; sbB = 1'b0; addrB = 32'd24;
        step();
        n_cmp++;
        if ({gntB, gntA} !== 2'b10) begin
            n_bad++; $display("FAIL hand_gntB: got gntB,gntA=%b want 10", {gntB, gntA});
        end
        reqB = 1'b0;
        step(); step();
    endtask

    task automatic test_reset_abort();
        int   w0;
        logic seen;
        // byte store then word load with ACC_CYCLES=3 latency
        reqA3 = 1'b1; weA3 = 1'b1; sbA3 = 1'b1; addrA3 = 32'd100; wdataA3 = 32'h00000055;
        step();
        n_cmp++;
        if (gntA3 !== 1'b1) begin
            n_bad++; $display("FAIL a3_gnt: got %b want 1", gntA3);
        end
        reqA3 = 1'b0;
        seen = 1'b0;
        step(); seen = seen | memWrite3;
        step(); seen = seen | memWrite3;
        step();
        n_cmp++;
        if ({seen, memWrite3, doneA3} !== 3'b010) begin
            n_bad++; $display("FAIL a3_write_t3: got early,memWrite,done=%b want 010", {seen, memWrite3, doneA3});
        end
        step();
        n_cmp++;
        if ({doneA3, errA3, memWrite3} !== 3'b100) begin
            n_bad++; $display("FAIL a3_done_t4: got done,err,memWrite=%b want 100", {doneA3, errA3, memWrite3});
        end
        reqA3 = 1'b1; weA3 = 1'b0; sbA3 = 1'b0; addrA3 = 32'd100;
        step();
        reqA3 = 1'b0;
        step(); step(); step(); step();
        n_cmp++;
        if (doneA3 !== 1'b1 || rdataA3 !== 32'h00000055) begin
            n_bad++; $display("FAIL a3_load100: got done=%b rdataA=%h want 1 00000055", doneA3, rdataA3);
        end
        // store aborted by reset in its second ACCESS cycle
        reqA3 = 1'b1; weA3 = 1'b1; sbA3 = 1'b0; addrA3 = 32'd40; wdataA3 = 32'h11223344;
        w0 = wr3;
        step();
        reqA3 = 1'b0;
        step();
        n_cmp++;
        if (dataAddress3 !== 32'd40) begin
            n_bad++; $display("FAIL abort_pre_addr: got %0d want 40", dataAddress3);
        end
        rst3_n = 1'b0;
        #1;
        n_cmp++;
        if ({gntA3, gntB3, doneA3, doneB3, errA3, errB3, memWrite3, sb3} !== 8'h00 ||
            {rdataA3, rdataB3, dataAddress3, writeData3} !== 128'd0) begin
            n_bad++;
            $display("FAIL abort_reset_vals: got flags=%b rdA=%h rdB=%h addr=%h wd=%h want all 0",
                     {gntA3, gntB3, doneA3, doneB3, errA3, errB3, memWrite3, sb3},
                     rdataA3, rdataB3, dataAddress3, writeData3);
        end
        step(); step();
        rst3_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            seen = seen | doneA3 | memWrite3 | gntA3;
        end
        n_cmp++;
        if (seen !== 1'b0 || (wr3 - w0) !== 0 || {mem3[43], mem3[42], mem3[41], mem3[40]} !== 32'd0) begin
            n_bad++;
            $display("FAIL abort_no_effect: got activity=%b writes=%0d mem40=%h want 0 0 0",
                     seen, wr3 - w0, {mem3[43], mem3[42], mem3[41], mem3[40]});
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_byte_store();
        test_arbitration();
        test_reject();
        test_wait();
        test_resp_handoff();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
